// File: rtl/operand_stage.sv
// Operand stage of the microcoded RV32I core: instruction register, integer
// register file, A/B operand latches and immediate decode feeding the ALU.
module operand_stage #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             irLoad,
   input  logic [31:0]      instrIn,
   input  logic [WIDTH-1:0] pcIn,
   input  logic             latchAB,
   input  logic             rfWe,
   input  logic [WIDTH-1:0] rfWdata,
   input  logic             aSel,
   input  logic [1:0]       bSel,
   output logic [WIDTH-1:0] aluA,
   output logic [WIDTH-1:0] aluB,
   output logic [WIDTH-1:0] storeData,
   output logic [WIDTH-1:0] immOut,
   output logic [31:0]      irOut
);

   localparam int IDXW = $clog2(NREGS);
   localparam logic [31:0] IR_NOP = 32'h0000_0013;

   logic [31:0]      ir;
   logic [WIDTH-1:0] rf [NREGS];
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;

   logic [IDXW-1:0]  rd;
   logic [IDXW-1:0]  rs1;
   logic [IDXW-1:0]  rs2;
   logic [6:0]       opcode;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic [31:0]      imm32;

   assign rd     = ir[7 +: IDXW];
   assign rs1    = ir[15 +: IDXW];
   assign rs2    = ir[20 +: IDXW];
   assign opcode = ir[6:0];

   // Write-first read ports: a same-cycle write to the source register is
   // forwarded so the latch never captures a stale value. x0 is hardwired.
   always_comb begin
      rd_a = rf[rs1];
      rd_b = rf[rs2];
      if (rfWe && (rd == rs1)) rd_a = rfWdata;
      if (rfWe && (rd == rs2)) rd_b = rfWdata;
      if (rs1 == '0) rd_a = '0;
      if (rs2 == '0) rd_b = '0;
   end

   // All updates use the IR fields as they stand before this edge, so an
   // irLoad in the same cycle only affects the following cycle.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ir    <= IR_NOP;
         reg_a <= '0;
         reg_b <= '0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         if (irLoad) ir <= instrIn;
         if (latchAB) begin
            reg_a <= rd_a;
            reg_b <= rd_b;
         end
         if (rfWe && (rd != '0)) rf[rd] <= rfWdata;
      end
   end

   always_comb begin
      imm32 = 32'h0;
      case (opcode)
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
            imm32 = {{20{ir[31]}}, ir[31:20]};
         7'b0100011:
            imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         7'b1100011:
            imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         7'b0110111, 7'b0010111:
            imm32 = {ir[31:12], 12'h000};
         7'b1101111:
            imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:
            imm32 = 32'h0;
      endcase
   end

   assign immOut = WIDTH'($signed(imm32));

   always_comb begin
      aluA = aSel ? pcIn : reg_a;
      case (bSel)
         2'd0:    aluB = reg_b;
         2'd1:    aluB = immOut;
         2'd2:    aluB = WIDTH'(4);
         default: aluB = '0;
      endcase
   end

   assign storeData = reg_b;
   assign irOut     = ir;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: register file, bypass, immediate decode,
// operand selects and asynchronous reset.
module tb_operand_stage;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rstN;
   logic             irLoad;
   logic [31:0]      instrIn;
   logic [WIDTH-1:0] pcIn;
   logic             latchAB;
   logic             rfWe;
   logic [WIDTH-1:0] rfWdata;
   logic             aSel;
   logic [1:0]       bSel;
   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [WIDTH-1:0] storeData;
   logic [WIDTH-1:0] immOut;
   logic [31:0]      irOut;

   int passed = 0;
   int total  = 0;

   operand_stage #(.WIDTH(WIDTH), .NREGS(32)) dut (
      .clk(clk), .rstN(rstN), .irLoad(irLoad), .instrIn(instrIn), .pcIn(pcIn),
      .latchAB(latchAB), .rfWe(rfWe), .rfWdata(rfWdata), .aSel(aSel), .bSel(bSel),
      .aluA(aluA), .aluB(aluB), .storeData(storeData), .immOut(immOut), .irOut(irOut)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers
   task automatic tick();
      @(posedge clk);
      #1;
      irLoad  = 1'b0;
      latchAB = 1'b0;
      rfWe    = 1'b0;
   endtask

   task automatic load_ir(input logic [31:0] instr);
      irLoad  = 1'b1;
      instrIn = instr;
      tick();
   endtask

   task automatic write_rd(input logic [WIDTH-1:0] data);
      rfWe    = 1'b1;
      rfWdata = data;
      tick();
   endtask

   task automatic latch();
      latchAB = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      #12;
      rstN = 1'b1;
      @(negedge clk);
      total++; if (aluA !== 32'h0) $display("FAIL reset_aluA got=%h exp=%h", aluA, 32'h0); else passed++;
      total++; if (aluB !== 32'h0) $display("FAIL reset_aluB got=%h exp=%h", aluB, 32'h0); else passed++;
      total++; if (irOut !== 32'h13) $display("FAIL reset_irOut got=%h exp=%h", irOut, 32'h13); else passed++;
      total++; if (immOut !== 32'h0) $display("FAIL reset_immOut got=%h exp=%h", immOut, 32'h0); else passed++;
      total++; if (storeData !== 32'h0) $display("FAIL reset_store got=%h exp=%h", storeData, 32'h0); else passed++;
   endtask

   task automatic test_x0();
      irLoad = 1'b1; instrIn = 32'h0; rfWe = 1'b1; rfWdata = 32'hDEADBEEF;
      tick();
      // IR = 0 now: rd = rs1 = rs2 = 0; write plus latch together must not bypass
      rfWe = 1'b1; rfWdata = 32'hDEADBEEF; latchAB = 1'b1;
      tick();
      total++; if (aluA !== 32'h0) $display("FAIL x0_bypass got=%h exp=%h", aluA, 32'h0); else passed++;
      latch();
      total++; if (aluA !== 32'h0) $display("FAIL x0_read got=%h exp=%h", aluA, 32'h0); else passed++;
      total++; if (storeData !== 32'h0) $display("FAIL x0_read_b got=%h exp=%h", storeData, 32'h0); else passed++;
   endtask

   task automatic test_write_read();
      load_ir(32'h00000293);       // addi x5,x0,0
      write_rd(32'h12345678);
      load_ir(32'h00028313);       // addi x6,x5,0
      latch();
      aSel = 1'b0;
      #1;
      total++; if (aluA !== 32'h12345678) $display("FAIL rf_read_x5 got=%h exp=%h", aluA, 32'h12345678); else passed++;
      total++; if (irOut !== 32'h00028313) $display("FAIL ir_load got=%h exp=%h", irOut, 32'h00028313); else passed++;
   endtask

   task automatic test_bypass();
      load_ir(32'h00528293);       // addi x5,x5,5
      rfWe = 1'b1; rfWdata = 32'hA5A5A5A5; latchAB = 1'b1;
      tick();
      total++; if (aluA !== 32'hA5A5A5A5) $display("FAIL bypass_a got=%h exp=%h", aluA, 32'hA5A5A5A5); else passed++;
      bSel = 2'd1;
      #1;
      total++; if (aluB !== 32'h5) $display("FAIL addi_imm got=%h exp=%h", aluB, 32'h5); else passed++;
      bSel = 2'd0;
      load_ir(32'h007003B3);       // add x7,x0,x7
      rfWe = 1'b1; rfWdata = 32'h0BADF00D; latchAB = 1'b1;
      tick();
      total++; if (storeData !== 32'h0BADF00D) $display("FAIL bypass_b got=%h exp=%h", storeData, 32'h0BADF00D); else passed++;
      total++; if (aluA !== 32'h0) $display("FAIL bypass_b_a got=%h exp=%h", aluA, 32'h0); else passed++;
   endtask

   task automatic test_old_ir();
      // IR is add x7,x0,x7: latch in the irLoad cycle reads rs1 = x0
      irLoad = 1'b1; instrIn = 32'h00028313; latchAB = 1'b1;
      tick();
      total++; if (aluA !== 32'h0) $display("FAIL old_ir_latch got=%h exp=%h", aluA, 32'h0); else passed++;
      latch();
      total++; if (aluA !== 32'hA5A5A5A5) $display("FAIL new_ir_latch got=%h exp=%h", aluA, 32'hA5A5A5A5); else passed++;
      repeat (5) tick();
      total++; if (aluA !== 32'hA5A5A5A5) $display("FAIL idle_hold got=%h exp=%h", aluA, 32'hA5A5A5A5); else passed++;
   endtask

   task automatic test_imm();
      logic [31:0] instrs [6] = '{32'hFE208CE3, 32'h0020A623, 32'h12345037,
                                  32'hFFDFF06F, 32'hFFF00093, 32'h8000007F};
      logic [31:0] exps   [6] = '{32'hFFFFFFF8, 32'h0000000C, 32'h12345000,
                                  32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000000};
      bSel = 2'd1;
      for (int i = 0; i < 6; i++) begin
         load_ir(instrs[i]);
         total++;
         if (immOut !== exps[i]) $display("FAIL imm_%0d ir=%h got=%h exp=%h", i, instrs[i], immOut, exps[i]);
         else passed++;
         total++;
         if (aluB !== exps[i]) $display("FAIL aluB_imm_%0d got=%h exp=%h", i, aluB, exps[i]);
         else passed++;
      end
   endtask

   task automatic test_selects();
      aSel = 1'b1; pcIn = 32'h00000100; bSel = 2'd2;
      #1;
      total++; if (aluA !== 32'h100) $display("FAIL sel_pc got=%h exp=%h", aluA, 32'h100); else passed++;
      total++; if (aluB !== 32'h4) $display("FAIL sel_four got=%h exp=%h", aluB, 32'h4); else passed++;
      bSel = 2'd3;
      #1;
      total++; if (aluB !== 32'h0) $display("FAIL sel_zero got=%h exp=%h", aluB, 32'h0); else passed++;
      aSel = 1'b0; bSel = 2'd0;
   endtask

   task automatic test_async_reset();
      load_ir(32'h00528293);
      rfWe = 1'b1; rfWdata = 32'h12345678; latchAB = 1'b1;
      tick();
      total++; if (aluA !== 32'h12345678) $display("FAIL pre_reset_a got=%h exp=%h", aluA, 32'h12345678); else passed++;
      #2;
      rstN = 1'b0;
      #1;
      total++; if (aluA !== 32'h0) $display("FAIL async_aluA got=%h exp=%h", aluA, 32'h0); else passed++;
      total++; if (irOut !== 32'h13) $display("FAIL async_irOut got=%h exp=%h", irOut, 32'h13); else passed++;
      #1;
      rstN = 1'b1;
      load_ir(32'h00028313);
      latch();
      total++; if (aluA !== 32'h0) $display("FAIL rf_cleared got=%h exp=%h", aluA, 32'h0); else passed++;
   endtask

   initial begin
      irLoad = 1'b0; instrIn = 32'h0; pcIn = 32'h0; latchAB = 1'b0;
      rfWe = 1'b0; rfWdata = 32'h0; aSel = 1'b0; bSel = 2'd0; rstN = 1'b1;
      test_reset();
      test_x0();
      test_write_read();
      test_bypass();
      test_old_ir();
      test_imm();
      test_selects();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Upstream neighbour of the combinational ALU in the microcoded RV32I core.
- Holds the instruction register (IR), the 32-entry integer register file and the A/B operand latches.
- Decodes the immediate and drives the ALU inA/inB through microcode-controlled selects.
- All state changes happen only when microcode asserts the load and write enables.

Parameters:
- WIDTH, 32, datapath width; must equal the ALU WIDTH.
- NREGS, 32, number of architectural registers; index width is $clog2(NREGS) = 5.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rstN  input  1  asynchronous, active-low reset.
- irLoad  input  1  capture instrIn into IR.
- instrIn  input  32  fetched instruction word.
- pcIn  input  WIDTH  current PC, used as the A operand source.
- latchAB  input  1  capture rf[IR.rs1] into regA and rf[IR.rs2] into regB.
- rfWe  input  1  write rfWdata into rf[IR.rd].
- rfWdata  input  WIDTH  writeback data (ALU result or load data).
- aSel  input  1  A operand select: 0 = regA, 1 = pcIn.
- bSel  input  2  B operand select: 0 = regB, 1 = imm, 2 = constant 4, 3 = zero.
- aluA  output  WIDTH  to ALU inA.
- aluB  output  WIDTH  to ALU inB.
- storeData  output  WIDTH  regB, to the memory interface.
- immOut  output  WIDTH  decoded, sign-extended immediate.
- irOut  output  32  current IR, to the microcode sequencer for dispatch.

Behaviour:
- Reset (rstN low, asynchronous, takes effect immediately mid-operation):
  - IR = 32'h00000013 (addi x0,x0,0).
  - regA = regB = 0 and all register-file entries = 0.
  - With aSel/bSel at 0, aluA = aluB = storeData = 0.
  - immOut = 0, irOut = 32'h00000013.
- Field extraction from IR: rd = IR[11:7], rs1 = IR[19:15], rs2 = IR[24:20], opcode = IR[6:0].
- Register file:
  - x0 reads as 0 at all times.
  - A write with rd = 0 is discarded.
  - Writes occur at the clk edge when rfWe = 1.
- latchAB:
  - At the edge, regA <= rf[rs1] and regB <= rf[rs2].
  - If rfWe is active in the same cycle and rd == rs1 (or rd == rs2) with rd != 0, the latch captures rfWdata, i.e. write-first bypass.
- Simultaneous events in one cycle:
  - irLoad with latchAB or rfWe: latchAB and rfWe use the OLD IR fields; the new IR is visible from the next cycle.
  - All three may be asserted together.
- Immediate decode (combinational from IR, sign bit IR[31]):
  - I-type, opcode 0010011 / 0000011 / 1100111 / 1110011: sext(IR[31:20]).
  - S-type, opcode 0100011: sext({IR[31:25], IR[11:7]}).
  - B-type, opcode 1100011: sext({IR[31], IR[7], IR[30:25], IR[11:8], 0}).
  - U-type, opcode 0110111 / 0010111: {IR[31:12], 12'b0}.
  - J-type, opcode 1101111: sext({IR[31], IR[19:12], IR[20], IR[30:21], 0}).
  - Any other opcode: 0.
  - Shift immediates are passed unmodified; the ALU masks the shift amount to 5 bits.
- Output paths:
  - aluA, aluB and immOut are purely combinational from registered state plus pcIn/aSel/bSel, with no extra latency.
  - Operands are valid at the ALU in the cycle after the latchAB edge.
  - storeData = regB.
- Pipeline latency:
  - Instruction presented with irLoad at edge N.
  - latchAB at edge N+1.
  - ALU operands valid after edge N+1.
  - Writeback with rfWe at edge N+2 or later.
- No internal FSM; sequencing is owned by microcode. Enables held low leave all state unchanged indefinitely.

Test Plan:
- Reset -> aluA = aluB = 0, irOut = 0x00000013; then irLoad 0x00000000 with rfWe = 1, rfWdata = 0xDEADBEEF -> rf[x0] is unchanged and reads as 0.
- Load IR with rd = x5, rfWe = 1, rfWdata = 0x12345678; then load IR addi x6,x5,0 (0x00028313) and latchAB; aSel = 0 -> aluA = 0x12345678.
- Bypass: with IR = 0x00528293 (addi x5,x5,5), assert rfWe = 1, rfWdata = 0xA5A5A5A5 and latchAB in the same cycle -> regA = 0xA5A5A5A5.
- Immediate decode:
  - IR = 0xFE208CE3 (beq x1,x2,-8), bSel = 1 -> aluB = 0xFFFFFFF8.
  - IR = 0x0020A623 (sw x2,12(x1)) -> immOut = 0x0000000C.
- Selects: aSel = 1 with pcIn = 0x00000100, bSel = 2 -> aluA = 0x100, aluB = 4; bSel = 3 -> aluB = 0.
- Async reset mid-operation: pull rstN low between edges after regA = 0x12345678 -> aluA = 0 immediately, without waiting for a clock edge; rf[x5] reads 0 after release.
